// File: rtl/exu_upper_buf.sv
// exu_upper_buf: LUI/AUIPC execute unit with a small in-order result FIFO
// feeding a valid/ready writeback port.
//   XLEN      : datapath / PC width (32 or 64)
//   PC_OFFSET : constant removed from pc for AUIPC
//   BUF_DEPTH : result FIFO depth (power of 2, >= 2)
// Optional macro EXU_UPPER_BYPASS_EN: zero-latency bypass from an
// accepting instruction straight to wb_* while the FIFO is empty.
module exu_upper_buf #(
  parameter int XLEN      = 32,
  parameter int PC_OFFSET = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic            hclk,
  input  logic            hrstn,
  input  logic [3:0]      cycle_cnt,
  input  logic            dec_upper_en,
  input  logic            dec_lui,
  input  logic            dec_auipc,
  input  logic [19:0]     dec_imm_type_u,
  input  logic [4:0]      dec_rd,
  input  logic [XLEN-1:0] pc,
  input  logic            exu_stall,
  input  logic            exu_flush,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_waddr,
  output logic [XLEN-1:0] wb_wdata,
  output logic            busy,
  output logic            full
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int EW = 5 + XLEN;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(BUF_DEPTH);

  // FIFO storage: entry = {rd, result}
  logic [BUF_DEPTH-1:0][EW-1:0] mem;
  logic [AW-1:0]                wr_ptr;
  logic [AW-1:0]                rd_ptr;
  logic [AW:0]                  cnt;

  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] result;
  logic [EW-1:0]   new_ent;
  logic [EW-1:0]   head;
  logic            accept;
  logic            push;
  logic            store;
  logic            pop;

  // U-type immediate, sign-extended from bit 31 on 64-bit builds
  generate
    if (XLEN == 64) begin : g_imm64
      assign imm = {{32{dec_imm_type_u[19]}}, dec_imm_type_u, 12'b0};
    end else begin : g_imm32
      assign imm = {dec_imm_type_u, 12'b0};
    end
  endgenerate

  // LUI has priority over AUIPC when both are flagged
  assign result  = dec_lui ? imm : (imm + pc - XLEN'(PC_OFFSET));
  assign new_ent = {dec_rd, result};

  // A full buffer refuses the instruction even if it drains this cycle;
  // the decoder re-presents it later.
  assign accept = dec_upper_en & (cycle_cnt == 4'd1) & ~exu_stall & ~full & ~exu_flush;
  // Writes to x0 and non-upper ops are accepted but produce nothing
  assign push   = accept & (dec_lui | dec_auipc) & (dec_rd != 5'd0);

  assign busy = (cnt != '0);
  assign full = (cnt == CNT_FULL);
  assign head = mem[rd_ptr];
  assign pop  = busy & wb_ready;

`ifdef EXU_UPPER_BYPASS_EN
  logic byp_hit;
  // Empty FIFO + pushing instruction: show the result this cycle; gated by
  // hrstn so outputs stay at zero while reset is held.
  assign byp_hit  = push & ~busy & hrstn;
  // A bypassed result consumed right away never enters the FIFO
  assign store    = push & ~(byp_hit & wb_ready);
  assign wb_valid = busy | byp_hit;
  assign wb_waddr = byp_hit ? dec_rd : (busy ? head[EW-1 -: 5] : 5'd0);
  assign wb_wdata = byp_hit ? result : (busy ? head[XLEN-1:0] : '0);
`else
  // Head is a pure decode of registered state; no decode-to-wb path
  assign store    = push;
  assign wb_valid = busy;
  assign wb_waddr = busy ? head[EW-1 -: 5] : 5'd0;
  assign wb_wdata = busy ? head[XLEN-1:0] : '0;
`endif

  // FIFO state: flush wins over same-cycle push/pop
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (exu_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (store) begin
        mem[wr_ptr] <= new_ent;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, store} - {{AW{1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_exu_upper_buf.sv
// Bench for exu_upper_buf: queue model checked every negedge against a
// 32-bit and a 64-bit instance, plus hand-computed literal expectations.
module tb_exu_upper_buf;

`ifdef EXU_UPPER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 2;

  logic        hclk = 1'b0;
  logic        hrstn;
  logic [3:0]  cycle_cnt;
  logic        en, lui, auipc, stall, flush, ready;
  logic [19:0] imm;
  logic [4:0]  rd;
  logic [31:0] pc;

  logic        v32, busy32, full32, v64, busy64, full64;
  logic [4:0]  a32, a64;
  logic [31:0] d32;
  logic [63:0] d64;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 hclk = ~hclk;

  exu_upper_buf #(.XLEN(32), .PC_OFFSET(8), .BUF_DEPTH(DEPTH)) u_dut32 (
    .hclk(hclk), .hrstn(hrstn), .cycle_cnt(cycle_cnt), .dec_upper_en(en),
    .dec_lui(lui), .dec_auipc(auipc), .dec_imm_type_u(imm), .dec_rd(rd),
    .pc(pc), .exu_stall(stall), .exu_flush(flush), .wb_valid(v32),
    .wb_ready(ready), .wb_waddr(a32), .wb_wdata(d32), .busy(busy32), .full(full32));

  exu_upper_buf #(.XLEN(64), .PC_OFFSET(8), .BUF_DEPTH(DEPTH)) u_dut64 (
    .hclk(hclk), .hrstn(hrstn), .cycle_cnt(cycle_cnt), .dec_upper_en(en),
    .dec_lui(lui), .dec_auipc(auipc), .dec_imm_type_u(imm), .dec_rd(rd),
    .pc({32'h0, pc}), .exu_stall(stall), .exu_flush(flush), .wb_valid(v64),
    .wb_ready(ready), .wb_waddr(a64), .wb_wdata(d64), .busy(busy64), .full(full64));

  // ---------------- model: queue of pending writebacks ----------------
  typedef struct packed { logic [4:0] rd; logic [63:0] d; } ent_t;
  ent_t q[$];

  function automatic bit mdl_push();
    return hrstn && en && cycle_cnt == 4'd1 && !stall && !flush &&
           q.size() < DEPTH && (lui || auipc) && rd != 5'd0;
  endfunction

  // Result in 64-bit arithmetic; low 32 bits give the XLEN=32 answer
  function automatic ent_t mdl_new();
    ent_t e;
    logic [63:0] im;
    im   = {{32{imm[19]}}, imm, 12'h000};
    e.rd = rd;
    e.d  = lui ? im : (im + {32'h0, pc} - 64'd8);
    return e;
  endfunction

  always @(negedge hrstn) q.delete();

  always @(posedge hclk) begin
    bit   p, taken;
    ent_t e;
    if (hrstn) begin
      if (flush) q.delete();
      else begin
        p     = mdl_push();
        e     = mdl_new();
        taken = BYP && q.size() == 0 && p && ready;
        if (q.size() > 0 && ready) void'(q.pop_front());
        if (p && !taken) q.push_back(e);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare of both instances against the model
  always @(negedge hclk) begin
    ent_t e;
    bit   v;
    v = 1'b0;
    e = '0;
    if (BYP && q.size() == 0 && mdl_push()) begin v = 1'b1; e = mdl_new(); end
    else if (q.size() > 0) begin v = 1'b1; e = q[0]; end
    chk("m_valid32", {63'h0, v32},    {63'h0, v});
    chk("m_waddr32", {59'h0, a32},    {59'h0, e.rd});
    chk("m_wdata32", {32'h0, d32},    {32'h0, e.d[31:0]});
    chk("m_busy32",  {63'h0, busy32}, {63'h0, q.size() != 0});
    chk("m_full32",  {63'h0, full32}, {63'h0, q.size() == DEPTH});
    chk("m_valid64", {63'h0, v64},    {63'h0, v});
    chk("m_waddr64", {59'h0, a64},    {59'h0, e.rd});
    chk("m_wdata64", d64,             e.d);
    chk("m_full64",  {63'h0, full64}, {63'h0, q.size() == DEPTH});
    chk("m_busy64",  {63'h0, busy64}, {63'h0, q.size() != 0});
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge hclk); #1;
  endtask

  task automatic idle();
    en = 0; lui = 0; auipc = 0; stall = 0; flush = 0; cycle_cnt = 4'd1;
  endtask

  task automatic drv(input logic l, input logic a, input logic [19:0] im,
                     input logic [4:0] r, input logic [31:0] p);
    en = 1; cycle_cnt = 4'd1; lui = l; auipc = a; imm = im; rd = r; pc = p;
  endtask

  // Small vector table: {lui, auipc, imm, rd, pc, ready}
  logic [19:0] t_imm [8] = '{20'h00010, 20'hFFFFF, 20'h7FFFF, 20'h00000,
                             20'h12345, 20'h80001, 20'h00ABC, 20'h55555};
  logic [4:0]  t_rd  [8] = '{5'd1, 5'd31, 5'd2, 5'd3, 5'd0, 5'd4, 5'd5, 5'd6};
  logic [31:0] t_pc  [8] = '{32'h0, 32'h1000, 32'hFFFF_FFF0, 32'h8, 32'h4,
                             32'h8000_0000, 32'h20, 32'h10};
  logic [7:0]  t_lui = 8'b1010_0101;
  logic [7:0]  t_aui = 8'b0111_1110;
  logic [7:0]  t_rdy = 8'b1100_1011;

  initial begin
    hrstn = 0; ready = 0; imm = '0; rd = '0; pc = '0;
    idle();
    cyc(); cyc();
    @(negedge hclk);
    chk("rst_valid", {63'h0, v32}, 64'h0);
    chk("rst_busy",  {63'h0, busy32}, 64'h0);
    chk("rst_full",  {63'h0, full32}, 64'h0);
    chk("rst_wdata64", d64, 64'h0);
    cyc(); hrstn = 1;

    // LUI 0x12345 -> x5, ready held high
    ready = 1; drv(1, 0, 20'h12345, 5'd5, 32'h0);
`ifdef EXU_UPPER_BYPASS_EN
    @(negedge hclk);
    chk("lui_byp_valid", {63'h0, v32}, 64'h1);
    chk("lui_byp_wdata", {32'h0, d32}, 64'h1234_5000);
`endif
    cyc(); idle();
`ifndef EXU_UPPER_BYPASS_EN
    @(negedge hclk);
    chk("lui_valid", {63'h0, v32}, 64'h1);
    chk("lui_waddr", {59'h0, a32}, 64'd5);
    chk("lui_wdata", {32'h0, d32}, 64'h1234_5000);
    cyc();
`endif
    @(negedge hclk);
    chk("lui_drained", {63'h0, busy32}, 64'h0);

    // AUIPC 0x00001 with pc=0x108
    cyc(); ready = 0; drv(0, 1, 20'h00001, 5'd3, 32'h108);
    cyc(); idle();
    @(negedge hclk);
    chk("auipc_wdata", {32'h0, d32}, 64'h0000_1100);
    chk("auipc_waddr", {59'h0, a32}, 64'd3);
    cyc(); ready = 1; cyc();
    @(negedge hclk);
    chk("auipc_drained", {63'h0, busy32}, 64'h0);

    // sign extension on 64-bit
    cyc(); ready = 0; drv(1, 0, 20'h80000, 5'd7, 32'h0);
    cyc(); idle();
    @(negedge hclk);
    chk("sext_wdata64", d64, 64'hFFFF_FFFF_8000_0000);
    chk("sext_wdata32", {32'h0, d32}, 64'h8000_0000);
    cyc(); ready = 1; cyc(); ready = 0;

    // three accepts into a depth-2 buffer with ready low
    drv(1, 0, 20'h11111, 5'd1, 32'h0); cyc();
    drv(1, 0, 20'h22222, 5'd2, 32'h0); cyc();
    drv(1, 0, 20'h33333, 5'd3, 32'h0); cyc(); idle();
    @(negedge hclk);
    chk("fill_full",  {63'h0, full32}, 64'h1);
    chk("fill_head",  {32'h0, d32}, 64'h1111_1000);
    cyc(); ready = 1; cyc();
    @(negedge hclk);
    chk("drain_2nd", {59'h0, a32}, 64'd2);
    chk("drain_2nd_d", {32'h0, d32}, 64'h2222_2000);
    cyc();
    @(negedge hclk);
    chk("drain_empty", {63'h0, busy32}, 64'h0);

    // rd=0 produces nothing; flush drops two entries
    cyc(); ready = 0; drv(1, 0, 20'hABCDE, 5'd0, 32'h0); cyc(); idle();
    @(negedge hclk);
    chk("rd0_nopush", {63'h0, busy32}, 64'h0);
    cyc(); drv(1, 0, 20'h00004, 5'd4, 32'h0); cyc();
    drv(1, 0, 20'h00006, 5'd6, 32'h0); cyc();
    drv(1, 0, 20'h00008, 5'd8, 32'h0); flush = 1; ready = 1; cyc();
    idle(); ready = 0;
    @(negedge hclk);
    chk("flush_valid", {63'h0, v32}, 64'h0);

    // gating: wrong cycle_cnt, stall, neither opcode
    cyc(); drv(1, 0, 20'h00009, 5'd9, 32'h0); cycle_cnt = 4'd2; cyc();
    drv(1, 0, 20'h00009, 5'd9, 32'h0); stall = 1; cyc();
    drv(0, 0, 20'h00009, 5'd9, 32'h0); stall = 0; cyc(); idle();
    @(negedge hclk);
    chk("gated_nopush", {63'h0, busy32}, 64'h0);

    // simultaneous push and pop keeps count and order
    cyc(); drv(1, 0, 20'h0000A, 5'd10, 32'h0); cyc();
    ready = 1; drv(1, 1, 20'h0000B, 5'd11, 32'h0); cyc(); idle();
    @(negedge hclk);
    chk("pushpop_head", {59'h0, a32}, 64'd11);
    chk("pushpop_full", {63'h0, full32}, 64'h0);
    cyc(); ready = 0;
    drv(1, 0, 20'h0000C, 5'd12, 32'h0); cyc();
    drv(1, 0, 20'h0000D, 5'd13, 32'h0); cyc();
    ready = 1; drv(1, 0, 20'h0000E, 5'd14, 32'h0); cyc(); idle(); ready = 0;
    @(negedge hclk);
    chk("full_pop_noacc", {59'h0, a32}, 64'd13);
    chk("full_pop_busy", {63'h0, busy32}, 64'h1);
    cyc(); ready = 1; cyc(); ready = 0;

    // AUIPC wrap below zero
    drv(0, 1, 20'h00000, 5'd15, 32'h0); cyc(); idle();
    @(negedge hclk);
    chk("wrap_wdata32", {32'h0, d32}, 64'hFFFF_FFF8);
    chk("wrap_wdata64", d64, 64'hFFFF_FFFF_FFFF_FFF8);
    cyc(); ready = 1; cyc(); ready = 0;

    // reset while full, then a fresh LUI
    drv(1, 0, 20'h00010, 5'd16, 32'h0); cyc();
    drv(1, 0, 20'h00011, 5'd17, 32'h0); cyc(); idle();
    #2 hrstn = 0;
    #1;
    chk("mrst_valid", {63'h0, v32}, 64'h0);
    chk("mrst_full",  {63'h0, full32}, 64'h0);
    chk("mrst_waddr", {59'h0, a32}, 64'h0);
    chk("mrst_wdata", {32'h0, d32}, 64'h0);
    cyc(); hrstn = 1;
    drv(1, 0, 20'h0BEEF, 5'd18, 32'h0);
`ifdef EXU_UPPER_BYPASS_EN
    @(negedge hclk);
    chk("post_rst_byp", {32'h0, d32}, 64'h0BEE_F000);
`endif
    cyc(); idle();
    @(negedge hclk);
    chk("post_rst_waddr", {59'h0, a32}, 64'd18);
    chk("post_rst_wdata", {32'h0, d32}, 64'h0BEE_F000);
    cyc(); ready = 1; cyc();

    // table sweep, checked by the model each cycle
    for (int i = 0; i < 8; i++) begin
      drv(t_lui[i], t_aui[i], t_imm[i], t_rd[i], t_pc[i]);
      ready = t_rdy[i];
      cyc();
    end
    idle(); ready = 1;
    repeat (4) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/exu_upper_buf.md
EXU_UPPER_BUF -- requirements
Module: exu_upper_buf

Interface
Parameters (name, default, meaning):
- REQ-001 The block SHALL have parameter XLEN, default 32, giving the datapath and PC width; the only legal values are 32 and 64.
- REQ-002 The block SHALL have parameter PC_OFFSET, default 8, a constant subtracted from pc for AUIPC.
- REQ-003 The block SHALL have parameter BUF_DEPTH, default 2, giving the result buffer depth; it SHALL be a power of 2 and at least 2.

Ports (name, direction, width, meaning):
- REQ-004 hclk, input, 1: the single clock; all state is updated on its rising edge.
- REQ-005 hrstn, input, 1: reset, asynchronous and active-low.
- REQ-006 Decode inputs:
  - cycle_cnt, input, 4
  - dec_upper_en, input, 1
  - dec_lui, input, 1
  - dec_auipc, input, 1
  - dec_imm_type_u, input, 20
  - dec_rd, input, 5
  - pc, input, XLEN
- REQ-007 Pipeline controls:
  - exu_stall, input, 1
  - exu_flush, input, 1: drops all buffered results.
- REQ-008 Writeback port:
  - wb_valid, output, 1
  - wb_ready, input, 1
  - wb_waddr, output, 5
  - wb_wdata, output, XLEN
- REQ-009 Status outputs:
  - busy, output, 1: buffer non-empty.
  - full, output, 1: buffer holds BUF_DEPTH entries.

Function
- REQ-010 Accept SHALL be asserted exactly when dec_upper_en=1, cycle_cnt=1, exu_stall=0, full=0 and exu_flush=0 are all true.
- REQ-011 imm SHALL be {dec_imm_type_u, 12'b0}, sign-extended from bit 31 to XLEN.
- REQ-012 The result SHALL be imm when dec_lui=1, and imm + pc - PC_OFFSET (modulo 2^XLEN) when dec_lui=0 and dec_auipc=1; dec_lui SHALL win if both are set.
- REQ-013 An accept with neither dec_lui nor dec_auipc set, or with dec_rd=0, SHALL push nothing and SHALL leave the buffer unchanged.
- REQ-014 An accepted result SHALL be pushed as {dec_rd, result} into a FIFO of BUF_DEPTH entries, using a write pointer, a read pointer and a count.
- REQ-015 Pointers SHALL wrap modulo BUF_DEPTH.
- REQ-016 The count SHALL range from 0 to BUF_DEPTH.
- REQ-017 wb_valid SHALL equal busy, and wb_waddr/wb_wdata SHALL present the FIFO head.
- REQ-018 While wb_valid=0, wb_waddr and wb_wdata SHALL be driven to 0.
- REQ-019 An entry SHALL be popped on a cycle where wb_valid=1 and wb_ready=1.
- REQ-020 While wb_valid=1 and wb_ready=0, the head (wb_valid, wb_waddr, wb_wdata) SHALL be held stable.
- REQ-021 Latency: a result accepted at edge N SHALL be visible on wb_* after edge N, provided the FIFO was empty.
- REQ-022 Simultaneous push and pop when not full SHALL leave the count unchanged and preserve FIFO order.
- REQ-023 When full=1, an accept SHALL NOT occur even if a pop happens in the same cycle; the decoder must re-present the instruction.
- REQ-024 When exu_flush=1, the next edge SHALL zero both pointers and the count, and same-cycle pushes and pops SHALL be ignored.
- REQ-025 full SHALL equal (count == BUF_DEPTH), and busy SHALL equal (count != 0).
- REQ-026 All outputs SHALL be glitch-free registered or pure decodes of registered state; wb_ready SHALL NOT combinationally affect any output.

Reset
- REQ-027 When hrstn=0, pointers, count and all buffer entries SHALL be cleared to 0 asynchronously.
- REQ-028 During reset, wb_valid, busy and full SHALL be 0, and wb_waddr and wb_wdata SHALL be 0.
- REQ-029 Reset asserted mid-operation SHALL discard all pending entries, and the first accept after reset deassertion SHALL behave as if the FIFO were empty.

Configuration
- REQ-030 Macro EXU_UPPER_BYPASS_EN, when defined, SHALL enable zero-latency bypass: with the FIFO empty and an accept that pushes, wb_valid, wb_waddr and wb_wdata SHALL present the new result in the same cycle.
- REQ-031 Under EXU_UPPER_BYPASS_EN, a bypassed result taken in the same cycle (wb_ready=1) SHALL NOT be stored; otherwise it SHALL be stored normally.
- REQ-032 Without EXU_UPPER_BYPASS_EN, no combinational path SHALL exist from decode inputs to wb_*, and latency SHALL be as stated in REQ-021.

Verification
- REQ-033 LUI with imm=0x12345, rd=5, XLEN=32 and wb_ready=1: the next cycle SHALL show wb_valid=1, wb_waddr=5, wb_wdata=0x12345000, and the FIFO SHALL then be empty.
- REQ-034 AUIPC with imm=0x00001, pc=0x108, PC_OFFSET=8: the result SHALL be wb_wdata=0x00001100.
- REQ-035 With XLEN=64 and LUI imm=0x80000, the result SHALL be wb_wdata=0xFFFFFFFF80000000.
- REQ-036 With wb_ready=0, three accepts at BUF_DEPTH=2: the first two are stored, full=1, and the third SHALL NOT be accepted; then with wb_ready=1, the SHALL be drained in order over 2 cycles, ending with busy=0.
- REQ-037 LUI with rd=0 SHALL produce no push; a flush with 2 entries buffered SHALL produce wb_valid=0 the next cycle.
- REQ-038 hrstn pulsed low while full=1 SHALL clear all outputs to 0 immediately; a following LUI SHALL emerge correctly one cycle later (zero cycles later with EXU_UPPER_BYPASS_EN).
